// File: rtl/sel_sort_engine.sv
// ============================================================================
// Module   : sel_sort_engine
// Purpose  : In-place selection sorter over a single-port memory with a
//            combinational read path. Sorts words 0..Len-1 ascending or
//            descending, skips self-swaps and counts the swaps it performs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sel_sort_engine #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Start,
    input  logic              Abort,
    input  logic              Descend,
    input  logic [ADDR_W:0]   Len,
    output logic              Busy,
    output logic              Done,
    output logic [ADDR_W-1:0] Swap_Count,
    output logic [ADDR_W-1:0] Mem_Addr,
    input  logic [DATA_W-1:0] Mem_Rd_Data,
    output logic [DATA_W-1:0] Mem_Wr_Data,
    output logic              Mem_Wr_En
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_I = 3'd1,
        S_SCAN   = 3'd2,
        S_WR_MIN = 3'd3,
        S_WR_I   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    // Length constants at the width of the loop indices.
    localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE     = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] TWO     = {{(ADDR_W-1){1'b0}}, 2'b10};

    state_t              state_q, state_d;
    logic [ADDR_W:0]     i_q, i_d;
    logic [ADDR_W:0]     j_q, j_d;
    logic [ADDR_W:0]     len_q, len_d;
    logic                desc_q, desc_d;
    logic [DATA_W-1:0]   min_val_q, min_val_d;
    logic [DATA_W-1:0]   temp_q, temp_d;
    logic [ADDR_W-1:0]   min_addr_q, min_addr_d;
    logic [ADDR_W-1:0]   swap_q, swap_d;

    logic                better;
    logic                last_i;

    // State and datapath registers, all cleared asynchronously.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q    <= S_IDLE;
            i_q        <= '0;
            j_q        <= '0;
            len_q      <= '0;
            desc_q     <= 1'b0;
            min_val_q  <= '0;
            temp_q     <= '0;
            min_addr_q <= '0;
            swap_q     <= '0;
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            j_q        <= j_d;
            len_q      <= len_d;
            desc_q     <= desc_d;
            min_val_q  <= min_val_d;
            temp_q     <= temp_d;
            min_addr_q <= min_addr_d;
            swap_q     <= swap_d;
        end
    end

    // Next-state, datapath update and memory-port control.
    always_comb begin
        state_d     = state_q;
        i_d         = i_q;
        j_d         = j_q;
        len_d       = len_q;
        desc_d      = desc_q;
        min_val_d   = min_val_q;
        temp_d      = temp_q;
        min_addr_d  = min_addr_q;
        swap_d      = swap_q;
        Mem_Addr    = '0;
        Mem_Wr_Data = '0;
        Mem_Wr_En   = 1'b0;

        // Strict compare so equal keys never displace the current pick.
        better = desc_q ? (Mem_Rd_Data > min_val_q) : (Mem_Rd_Data < min_val_q);
        // Outer pass i == len-2 is the last one that can move anything.
        last_i = (i_q == (len_q - TWO));

        case (state_q)
            S_IDLE: begin
                if (Start && !Abort) begin
                    len_d  = (Len > MAX_LEN) ? MAX_LEN : Len;
                    desc_d = Descend;
                    swap_d = '0;
                    i_d    = '0;
                    state_d = (Len <= ONE) ? S_DONE : S_LOAD_I;
                end
            end

            S_LOAD_I: begin
                Mem_Addr   = i_q[ADDR_W-1:0];
                min_val_d  = Mem_Rd_Data;
                temp_d     = Mem_Rd_Data;
                min_addr_d = i_q[ADDR_W-1:0];
                j_d        = i_q + ONE;
                state_d    = S_SCAN;
            end

            S_SCAN: begin
                Mem_Addr = j_q[ADDR_W-1:0];
                if (better) begin
                    min_val_d  = Mem_Rd_Data;
                    min_addr_d = j_q[ADDR_W-1:0];
                end
                j_d = j_q + ONE;
                if (j_q == (len_q - ONE)) begin
                    // Decision uses the minimum including this cycle's word.
                    if (min_addr_d != i_q[ADDR_W-1:0]) begin
                        state_d = S_WR_MIN;
                    end else if (last_i) begin
                        state_d = S_DONE;
                    end else begin
                        i_d     = i_q + ONE;
                        state_d = S_LOAD_I;
                    end
                end
            end

            S_WR_MIN: begin
                Mem_Addr    = min_addr_q;
                Mem_Wr_Data = temp_q;
                Mem_Wr_En   = 1'b1;
                state_d     = S_WR_I;
            end

            S_WR_I: begin
                Mem_Addr    = i_q[ADDR_W-1:0];
                Mem_Wr_Data = min_val_q;
                Mem_Wr_En   = 1'b1;
                swap_d      = swap_q + 1'b1;
                if (last_i) begin
                    state_d = S_DONE;
                end else begin
                    i_d     = i_q + ONE;
                    state_d = S_LOAD_I;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort wins over everything; the swap count is left as it was.
        if (Abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            swap_d  = swap_q;
        end
    end

    assign Busy       = (state_q != S_IDLE);
    assign Done       = (state_q == S_DONE);
    assign Swap_Count = swap_q;

endmodule

`default_nettype wire
